// File: rtl/neopixel_ws2812_serializer_pkg.sv
// Shared neopixel definitions: WS2812 timing defaults (in 10 MHz cycles)
// and the serializer FSM state encoding.
package neopixel_ws2812_serializer_pkg;

  localparam int CLK_FREQ_HZ = 10_000_000;
  localparam int T0H_DEF     = 4;
  localparam int T1H_DEF     = 8;
  localparam int TBIT_DEF    = 12;
  localparam int TLATCH_DEF  = 600;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } fsmState_t;

endpackage

// File: rtl/neopixel_ws2812_serializer_bit_encoder.sv
// Turns the current bit value and its position inside the bit period into
// the WS2812 line level, registered so neoData is glitch-free.
module neopixel_bit_encoder #(
  parameter int T0H   = 4,
  parameter int T1H   = 8,
  parameter int CYC_W = 4
) (
  input  logic             clk10mhz,
  input  logic             apbPresern,
  input  logic             enable,
  input  logic             bitVal,
  input  logic [CYC_W-1:0] cycCnt,
  output logic             neoData
);

  logic [CYC_W-1:0] highTime;
  logic             level;

  always_comb begin
    highTime = bitVal ? CYC_W'(T1H) : CYC_W'(T0H);
    level    = enable && (cycCnt < highTime);
  end

  always_ff @(posedge clk10mhz or negedge apbPresern) begin
    if (!apbPresern) begin
      neoData <= 1'b0;
    end else begin
      neoData <= level;
    end
  end

endmodule

// File: rtl/neopixel_ws2812_serializer.sv
// WS2812 serializer: accepts pixel bytes over valid/ready, shifts them out
// MSB first and closes each frame with a low latch period.
module neopixel_ws2812_serializer
  import neopixel_ws2812_serializer_pkg::*;
#(
  parameter int T0H    = T0H_DEF,
  parameter int T1H    = T1H_DEF,
  parameter int TBIT   = TBIT_DEF,
  parameter int TLATCH = TLATCH_DEF
) (
  input  logic       clk10mhz,
  input  logic       apbPresern,
  input  logic [7:0] byteData,
  input  logic       byteValid,
  input  logic       byteLast,
  output logic       byteReady,
  output logic       neoData,
  output logic       neoState,
  output logic       frameDone,
  output logic       underrun
);

  localparam int CYC_W   = $clog2(TBIT);
  localparam int LATCH_W = $clog2(TLATCH);
  localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(TBIT - 1);
  localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(TLATCH - 1);

  fsmState_t          state, stateNext;
  logic [7:0]         shiftReg, shiftNext;
  logic [2:0]         bitIdx, bitIdxNext;
  logic [CYC_W-1:0]   cycCnt, cycCntNext;
  logic [LATCH_W-1:0] latchCnt, latchCntNext;
  logic               lastFlag, lastNext;
  logic               readyNext, doneNext, underrunNext;
  logic               accept, loadByte;

  assign accept   = byteValid && byteReady;
  assign neoState = (state != IDLE);

  always_ff @(posedge clk10mhz or negedge apbPresern) begin
    if (!apbPresern) begin
      state     <= IDLE;
      shiftReg  <= '0;
      bitIdx    <= '0;
      cycCnt    <= '0;
      latchCnt  <= '0;
      lastFlag  <= 1'b0;
      byteReady <= 1'b0;
      frameDone <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= stateNext;
      shiftReg  <= shiftNext;
      bitIdx    <= bitIdxNext;
      cycCnt    <= cycCntNext;
      latchCnt  <= latchCntNext;
      lastFlag  <= lastNext;
      byteReady <= readyNext;
      frameDone <= doneNext;
      underrun  <= underrunNext;
    end
  end

  // Handshake outputs are registered, so they are derived from the next-state
  // values; a byte boundary loads the following byte with no idle cycle.
  always_comb begin
    stateNext    = state;
    shiftNext    = shiftReg;
    bitIdxNext   = bitIdx;
    cycCntNext   = cycCnt;
    latchCntNext = latchCnt;
    lastNext     = lastFlag;
    underrunNext = 1'b0;
    loadByte     = 1'b0;

    case (state)
      IDLE: begin
        loadByte = accept;
      end
      SEND: begin
        if (cycCnt == CYC_LAST) begin
          if (bitIdx != 3'd0) begin
            shiftNext  = {shiftReg[6:0], 1'b0};
            bitIdxNext = bitIdx - 3'd1;
            cycCntNext = '0;
          end else if (accept) begin
            loadByte = 1'b1;
          end else begin
            stateNext    = LATCH;
            cycCntNext   = '0;
            latchCntNext = '0;
            underrunNext = !lastFlag;
          end
        end else begin
          cycCntNext = cycCnt + 1'b1;
        end
      end
      LATCH: begin
        if (latchCnt == LATCH_LAST) begin
          stateNext    = IDLE;
          latchCntNext = '0;
        end else begin
          latchCntNext = latchCnt + 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    if (loadByte) begin
      stateNext  = SEND;
      shiftNext  = byteData;
      lastNext   = byteLast;
      bitIdxNext = 3'd7;
      cycCntNext = '0;
    end

    readyNext = (stateNext == IDLE) ||
                ((stateNext == SEND) && (cycCntNext == CYC_LAST) &&
                 (bitIdxNext == 3'd0) && !lastNext);
    doneNext  = (stateNext == LATCH) && (latchCntNext == LATCH_LAST);
  end

  neopixel_bit_encoder #(
    .T0H  (T0H),
    .T1H  (T1H),
    .CYC_W(CYC_W)
  ) bitEncoder (
    .clk10mhz  (clk10mhz),
    .apbPresern(apbPresern),
    .enable    (state == SEND),
    .bitVal    (shiftReg[7]),
    .cycCnt    (cycCnt),
    .neoData   (neoData)
  );

endmodule

// File: tb/tb_neopixel_ws2812_serializer.sv
// Directed bench for the WS2812 serializer: waveform model plus a pulse
// decoder that turns the measured neoData line back into bytes.
`timescale 1ns/1ps
module tb_neopixel_ws2812_serializer;

  logic       clk10mhz;
  logic       apbPresern;
  logic [7:0] byteData;
  logic       byteValid;
  logic       byteLast;
  logic       byteReady;
  logic       neoData;
  logic       neoState;
  logic       frameDone;
  logic       underrun;

  int checkCount = 0;
  int errorCount = 0;

  neopixel_ws2812_serializer dut (
    .clk10mhz  (clk10mhz),
    .apbPresern(apbPresern),
    .byteData  (byteData),
    .byteValid (byteValid),
    .byteLast  (byteLast),
    .byteReady (byteReady),
    .neoData   (neoData),
    .neoState  (neoState),
    .frameDone (frameDone),
    .underrun  (underrun)
  );

  initial clk10mhz = 1'b0;
  always #50 clk10mhz = ~clk10mhz;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic v, input logic l);
    byteData  = d;
    byteValid = v;
    byteLast  = l;
  endtask

  task automatic stepCycle();
    @(posedge clk10mhz);
    #1;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int c = 0;
    while (!(neoState == 1'b0 && byteReady == 1'b1) && c < budget) begin
      stepCycle();
      c++;
    end
    checkOutput({tag, " reachIdle"}, {31'd0, (neoState == 1'b0 && byteReady == 1'b1)}, 1);
  endtask

  // Line level expected in sample s, counted from the first transfer edge.
  function automatic bit expNeo(input logic [7:0] data[$], input int s);
    int k, i, c;
    logic b;
    if (s < 1 || s > 96 * data.size()) return 1'b0;
    k = s - 1;
    i = k / 96;
    b = data[i][7 - ((k % 96) / 12)];
    c = k % 12;
    return (c < (b ? 8 : 4));
  endfunction

  task automatic runFrame(input logic [7:0] data[$], input bit withLast,
                          input string tag, output int highCount);
    int n, len, idx, lastIdx;
    int errNeo, errRdy, errSt, errDone, errUnd;
    int i, w, prevRise, bitsGot, badW, badP, badB;
    logic [7:0] cur;
    logic acceptNow, expRdy;
    bit neoQ[$];
    n = data.size();
    len = 96 * n + 601;
    lastIdx = 96 * n + 599;
    idx = 0; highCount = 0;
    errNeo = 0; errRdy = 0; errSt = 0; errDone = 0; errUnd = 0;
    checkOutput({tag, " startReady"}, {31'd0, byteReady}, 1);
    applyStimulus(data[0], 1'b1, withLast && n == 1);
    for (int s = 0; s < len; s++) begin
      acceptNow = byteValid && byteReady;
      stepCycle();
      if (acceptNow) begin
        idx++;
        if (idx < n) applyStimulus(data[idx], 1'b1, withLast && idx == n - 1);
        else         applyStimulus(8'h00, 1'b0, 1'b0);
      end
      neoQ.push_back(neoData);
      if (neoData) highCount++;
      if (s > lastIdx) expRdy = 1'b1;
      else expRdy = (s % 96 == 95) && (s / 96 < n) && ((s / 96 != n - 1) || !withLast);
      if (neoData !== expNeo(data, s))             errNeo++;
      if (byteReady !== expRdy)                    errRdy++;
      if (neoState !== (s <= lastIdx))             errSt++;
      if (frameDone !== (s == lastIdx))            errDone++;
      if (underrun !== (!withLast && s == 96 * n)) errUnd++;
    end
    checkOutput({tag, " accepted"},   idx, n);
    checkOutput({tag, " waveErrs"},   errNeo, 0);
    checkOutput({tag, " readyErrs"},  errRdy, 0);
    checkOutput({tag, " stateErrs"},  errSt, 0);
    checkOutput({tag, " doneErrs"},   errDone, 0);
    checkOutput({tag, " underErrs"},  errUnd, 0);

    // Reference decoder: classify each high pulse by width, check the period.
    i = 0; prevRise = -1; bitsGot = 0; badW = 0; badP = 0; badB = 0; cur = '0;
    while (i < neoQ.size()) begin
      if (neoQ[i] && (i == 0 || !neoQ[i-1])) begin
        w = 0;
        while (i + w < neoQ.size() && neoQ[i+w]) w++;
        if (prevRise >= 0 && i - prevRise != 12) badP++;
        prevRise = i;
        if (w == 8)      cur = {cur[6:0], 1'b1};
        else if (w == 4) cur = {cur[6:0], 1'b0};
        else             badW++;
        bitsGot++;
        if (bitsGot % 8 == 0 && bitsGot / 8 <= n && cur !== data[bitsGot/8 - 1]) badB++;
        i += w;
      end else begin
        i++;
      end
    end
    checkOutput({tag, " decodedBits"}, bitsGot, 8 * n);
    checkOutput({tag, " badWidths"},   badW, 0);
    checkOutput({tag, " badPeriods"},  badP, 0);
    checkOutput({tag, " badBytes"},    badB, 0);
  endtask

  initial begin
    logic [7:0] q[$];
    int hc, doneAt;

    applyStimulus(8'h00, 1'b0, 1'b0);
    apbPresern = 1'b0;
    repeat (2) @(posedge clk10mhz);
    #1;
    checkOutput("rst neoData",   {31'd0, neoData},   0);
    checkOutput("rst neoState",  {31'd0, neoState},  0);
    checkOutput("rst byteReady", {31'd0, byteReady}, 0);
    checkOutput("rst frameDone", {31'd0, frameDone}, 0);
    checkOutput("rst underrun",  {31'd0, underrun},  0);
    apbPresern = 1'b1;
    stepCycle();
    checkOutput("post-rst byteReady", {31'd0, byteReady}, 1);

    q = '{8'h80};
    runFrame(q, 1'b1, "f80", hc);
    checkOutput("f80 highCycles", hc, 36);

    q = '{8'hFF, 8'h00, 8'hA5};
    runFrame(q, 1'b1, "f3", hc);
    checkOutput("f3 highCycles", hc, 144);

    q = '{8'h55};
    runFrame(q, 1'b0, "under", hc);
    checkOutput("under highCycles", hc, 48);

    // Reset 30 cycles into a 0xF0 byte, inside the high part of bit 5.
    applyStimulus(8'hF0, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(8'h00, 1'b0, 1'b0);
    repeat (30) stepCycle();
    checkOutput("midRst preHigh", {31'd0, neoData}, 1);
    #20;
    apbPresern = 1'b0;
    #1;
    checkOutput("midRst neoData",   {31'd0, neoData},   0);
    checkOutput("midRst neoState",  {31'd0, neoState},  0);
    checkOutput("midRst byteReady", {31'd0, byteReady}, 0);
    repeat (2) @(posedge clk10mhz);
    #1;
    apbPresern = 1'b1;
    stepCycle();
    checkOutput("midRst readyAfter", {31'd0, byteReady}, 1);
    checkOutput("midRst stateAfter", {31'd0, neoState},  0);
    checkOutput("midRst dataAfter",  {31'd0, neoData},   0);

    // Inputs offered during LATCH must wait for the first IDLE cycle.
    applyStimulus(8'h3C, 1'b1, 1'b1);
    stepCycle();
    applyStimulus(8'h00, 1'b0, 1'b0);
    repeat (300) stepCycle();
    checkOutput("latch ready",    {31'd0, byteReady}, 0);
    checkOutput("latch neoState", {31'd0, neoState},  1);
    applyStimulus(8'hC3, 1'b1, 1'b0);
    stepCycle();
    checkOutput("latchPulse ready", {31'd0, byteReady}, 0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    repeat (198) stepCycle();
    applyStimulus(8'hC3, 1'b1, 1'b1);
    doneAt = -1;
    for (int s = 500; s <= 696; s++) begin
      stepCycle();
      if (frameDone && doneAt < 0) doneAt = s;
    end
    checkOutput("latch doneAt",     doneAt, 695);
    checkOutput("latch idleState",  {31'd0, neoState},  0);
    checkOutput("latch idleReady",  {31'd0, byteReady}, 1);
    stepCycle();
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("latch acceptState", {31'd0, neoState},  1);
    checkOutput("latch acceptReady", {31'd0, byteReady}, 0);
    stepCycle();
    checkOutput("latch firstHigh", {31'd0, neoData}, 1);
    waitIdle("latch", 800);

    q.delete();
    for (int k = 0; k < 60; k++) q.push_back(8'($urandom_range(0, 255)));
    runFrame(q, 1'b1, "rand60", hc);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/neopixel_ws2812_serializer.md
Name: neopixel_ws2812_serializer

Overview:
Downstream stage of the neopixel pixel buffer. It takes pixel bytes, one at a time, over a valid/ready handshake and drives the single-wire WS2812 waveform on neoData, timed from clk10mhz. Bytes go out MSB first at 1.2 us per bit. Each frame ends with a low latch period so the LED strip latches the data.

Parameters:
T0H, 4, high time of a '0' bit in clk10mhz cycles (0.4 us)
T1H, 8, high time of a '1' bit in clk10mhz cycles (0.8 us)
TBIT, 12, total bit period in cycles (1.2 us); must be greater than T1H
TLATCH, 600, frame-end low time in cycles (60 us, above the 50 us WS2812 minimum)

Ports:
clk10mhz  in  1  sole clock, 10 MHz
apbPresern  in  1  asynchronous active-low reset
byteData  in  8  pixel byte (G, R, B order, as supplied by the buffer)
byteValid  in  1  byteData is valid
byteLast  in  1  qualifies byteData as the final byte of the frame
byteReady  out  1  serializer accepts the byte this cycle
neoData  out  1  WS2812 serial line
neoState  out  1  1 while a frame is sending or latching, 0 when idle
frameDone  out  1  one-cycle pulse at the end of the latch period
underrun  out  1  one-cycle pulse when a frame ends without byteLast

Behaviour:
- Clocking and reset:
  - One clock (clk10mhz); reset is asynchronous and active-low (apbPresern).
  - Reset values: state=IDLE, neoData=0, neoState=0, byteReady=0 during reset, frameDone=0, underrun=0, all counters 0.
  - Reset asserted mid-bit or mid-latch aborts the operation immediately; neoData drops to 0 asynchronously.
- Handshake:
  - A transfer occurs on a rising edge where byteValid && byteReady.
  - byteReady is a registered output and depends on state only, never on byteValid.
- FSM states: IDLE, SEND, LATCH.
- IDLE:
  - byteReady=1, neoData=0, neoState=0.
  - On transfer: latch byteData into the shift register, latch byteLast into lastFlag, set bitIdx=7 and cycCnt=0, go to SEND.
  - neoData first rises on the cycle after the transfer (latency 1).
- SEND:
  - neoState=1.
  - cycCnt counts 0..TBIT-1.
  - neoData = (cycCnt < (shift[7] ? T1H : T0H)).
  - At cycCnt==TBIT-1: shift left by 1, decrement bitIdx, reset cycCnt to 0.
- SEND, byte boundary (cycCnt==TBIT-1 and bitIdx==0):
  - byteReady=1 in that cycle only, and only if lastFlag=0.
  - Transfer in that cycle: load the next byte seamlessly, with no gap cycle between bit 0 of one byte and bit 7 of the next.
  - lastFlag=1: go to LATCH without asserting byteReady.
  - lastFlag=0 and byteValid=0: pulse underrun and go to LATCH; the frame is terminated.
- LATCH:
  - neoData=0, neoState=1, byteReady=0.
  - Counts TLATCH cycles, then pulses frameDone in the final cycle and returns to IDLE.
- Boundary conditions:
  - byteValid held high continuously streams bytes back to back with no bubbles.
  - byteLast with byteValid=0 is ignored.
  - A single-byte frame (byteLast on the first byte) is legal.
  - Inputs during LATCH are ignored; no transfer is possible there.
- Widths:
  - cycCnt is $clog2(TBIT) bits; latch counter is $clog2(TLATCH) bits; bitIdx is 3 bits.
  - Counters never wrap; they are compared against the terminal value and cleared.

Decomposition:
- Shared neopixel package holds:
  - timing constants (T0H, T1H, TBIT, TLATCH defaults, clock frequency 10 MHz);
  - the FSM state enum (IDLE, SEND, LATCH).
- One natural sub-module, neopixel_bit_encoder:
  - takes the bit value plus cycCnt and produces the neoData level;
  - is combinational plus an output register.
- Top level keeps the FSM, shift register and handshake.

Test Plan:
- Reset, then a single byte 0x80 with byteLast=1:
  - neoData high 8 cycles, low 4, then seven times (high 4, low 8);
  - then low for 600 cycles, frameDone pulses at the end, neoState falls the cycle after.
- Three-byte frame 0xFF, 0x00, 0xA5 with byteValid held high:
  - byteReady high exactly at the cycle-95 and cycle-191 boundaries;
  - no gap cycles, 288 total send cycles, then the latch.
- Byte 0x55 (byteLast=0) followed by byteValid=0:
  - underrun pulses at the end of bit 0; LATCH is entered; no frameDone until 600 cycles later.
- apbPresern asserted at cycle 30 of a byte:
  - neoData=0 asynchronously, state=IDLE, byteReady=1 one cycle after release.
- byteValid pulsed during LATCH:
  - no transfer occurs and byteReady stays 0;
  - the byte is accepted on the first IDLE cycle.
- Randomized 60-byte frame against a reference decoder:
  - measured high times are only 4 or 8 cycles, period is 12;
  - decoded bytes match the stimulus.
